imem_loader: RTL and testbench
==============================

# imem_loader

Parametrised instruction memory for the IF stage. Successor to the fixed 256-byte instruction store: configurable byte depth and optional registered read. Adds byte-enabled word writes, a streaming byte loader for the debug unit with a valid/ready handshake and auto-incrementing pointer, and a sequential zero-fill engine that replaces a single-cycle array reset. Sits between the debug/loader path and the PC-addressed fetch port.

## Interface
- ADDR_W, 8, byte-address width; depth = 2^ADDR_W bytes, ADDR_W >= 3.
- REG_READ, 0: 0 = combinational fetch; 1 = registered fetch, 1-cycle latency.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (asserted at 0).
- clear_start  in  1  pulse; starts zero-fill when IDLE.
- busy  out  1  high in CLEAR or LOAD.
- load_start  in  1  pulse; enters LOAD when IDLE.
- load_base  in  ADDR_W  loader start byte address, sampled with load_start.
- load_valid  in  1  load_byte valid.
- load_byte  in  8  streamed byte.
- load_last  in  1  qualifies final byte of stream.
- load_ready  out  1  high only in LOAD.
- load_count  out  ADDR_W+1  bytes accepted since last load_start, saturating at 2^ADDR_W.
- wr_en  in  1  word write request.
- wr_addr  in  ADDR_W  word-write base byte address.
- wr_data  in  32  little-endian word.
- wr_be  in  4  byte enables; bit i covers wr_data[8i+7:8i].
- wr_drop  out  1  1-cycle pulse when wr_en is ignored (not IDLE).
- rd_en  in  1  fetch enable (used only when REG_READ=1).
- rd_addr  in  ADDR_W  fetch byte address.
- instruction  out  32  {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- rd_valid  out  1  fetch data valid.

## Operation
- Array: 2^ADDR_W bytes, little-endian. Every a+k is computed mod 2^ADDR_W: word accesses at the top wrap to byte 0.
- FSM states: CLEAR, IDLE, LOAD.
  - Reset asserted -> CLEAR, clear pointer 0. Array contents are not touched by reset itself.
  - CLEAR: each cycle writes 0 to 4 bytes at ptr..ptr+3, ptr += 4; after the write at ptr = 2^ADDR_W-4 -> IDLE. Duration is 2^ADDR_W/4 cycles.
  - IDLE: clear_start -> CLEAR (ptr 0). Else load_start -> LOAD, with ptr = load_base and load_count = 0. clear_start wins if both are set.
  - LOAD: on load_valid && load_ready, mem[ptr] <= load_byte, ptr++ (wraps), load_count++ (saturates). If load_last is set on an accepted byte, that byte is written, then -> IDLE. clear_start and load_start are ignored in LOAD.
- Word write: accepted only in IDLE with no transition starting that cycle. It writes the bytes with wr_be set. Otherwise it is dropped and wr_drop pulses for one cycle.
- Fetch:
  - REG_READ=0: instruction follows rd_addr combinationally; rd_valid = !busy.
  - REG_READ=1: on rd_en, instruction <= word at rd_addr; rd_valid <= !busy. Without rd_en, instruction holds and rd_valid <= 0.
- While busy, instruction content is unspecified and rd_valid is 0.

## Timing
- Reset values: busy=1, load_ready=0, load_count=0, wr_drop=0, rd_valid=0, registered instruction=0.
- First IDLE cycle after reset release: cycle 2^ADDR_W/4 (cycle 64 for ADDR_W=8).
- Writes commit at the clock edge.
  - REG_READ=0: the new data is visible the same cycle after that edge.
  - REG_READ=1, read and write to the same byte in one cycle: the read returns old data.
- load_ready is asserted the cycle after load_start and drops the cycle after the load_last byte is accepted.
- Reset mid-CLEAR or mid-LOAD aborts immediately, restarts CLEAR from 0, and clears load_count.

## Test plan
- Reset release, ADDR_W=8: busy=1 for exactly 64 cycles, then 0. Reading any address returns 0x00000000 with rd_valid=1.
- Word write wr_addr=0x10, data=0xDEADBEEF, be=4'b0101: fetch 0x10 returns 0x00AD00EF. Then be=4'b1111 at 0xFE: fetch 0xFE returns 0xDEADBEEF, and fetch 0x00 returns 0x0000DEAD (wrap).
- Load with load_base=0x20, stream 0x13,0x00,0x00,0x00 (last on byte 4), with load_valid gapped one cycle: load_count=4, IDLE reached, fetch 0x20 returns 0x00000013.
- wr_en during LOAD: wr_drop pulses once and memory is unchanged.
- Assert reset at the third loaded byte: load_count=0, busy=1 for 64 cycles, and the loaded bytes read back as 0.
- REG_READ=1: rd_en at cycle n gives data and rd_valid at n+1. Same-cycle write/read to 0x40 returns the old word, and the next read returns the new one.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-addressed instruction memory with zero-fill engine, streaming byte loader,
// byte-enabled word writes and a combinational or registered little-endian fetch port.
module imem_loader #(
    parameter int ADDR_W   = 8,
    parameter bit REG_READ = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              busy,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    output logic              wr_drop,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       instruction,
    output logic              rd_valid
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_CLR  = ADDR_W'(DEPTH - 4);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              wr_drop_q, wr_drop_d;

    logic [7:0]        mem_q [DEPTH];
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_waddr [4];
    logic [7:0]        mem_wdata [4];
    logic [ADDR_W-1:0] rd_lane_addr [4];
    logic [31:0]       rd_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            load_count_q <= '0;
            wr_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_count_q <= load_count_d;
            wr_drop_q    <= wr_drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        wr_drop_d    = 1'b0;
        mem_we       = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            mem_waddr[k] = ptr_q + ADDR_W'(k);
            mem_wdata[k] = 8'h00;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 4'b1111;
                ptr_d     = ptr_q + ADDR_W'(4);
                wr_drop_d = wr_en;
                if (ptr_q == LAST_CLR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    ptr_d     = '0;
                    wr_drop_d = wr_en;
                end else if (load_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = load_base;
                    load_count_d = '0;
                    wr_drop_d    = wr_en;
                end else if (wr_en) begin
                    // Lane addresses wrap modulo the depth, so a word at the top spills into byte 0.
                    mem_we = wr_be;
                    for (int k = 0; k < 4; k++) begin
                        mem_waddr[k] = wr_addr + ADDR_W'(k);
                        mem_wdata[k] = wr_data[8*k +: 8];
                    end
                end
            end
            ST_LOAD: begin
                wr_drop_d = wr_en;
                if (load_valid) begin
                    mem_we[0]    = 1'b1;
                    mem_wdata[0] = load_byte;
                    ptr_d        = ptr_q + ADDR_W'(1);
                    if (load_count_q != COUNT_MAX) begin
                        load_count_d = load_count_q + (ADDR_W + 1)'(1);
                    end
                    if (load_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // The array is deliberately outside the reset domain; zeroing is done by the CLEAR walk.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_waddr[k]] <= mem_wdata[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_lane_addr[k] = rd_addr + ADDR_W'(k);
        end
        rd_word = {mem_q[rd_lane_addr[3]], mem_q[rd_lane_addr[2]],
                   mem_q[rd_lane_addr[1]], mem_q[rd_lane_addr[0]]};
    end

    assign busy       = (state_q != ST_IDLE);
    assign load_ready = (state_q == ST_LOAD);
    assign load_count = load_count_q;
    assign wr_drop    = wr_drop_q;

    generate
        if (REG_READ) begin : g_reg_read
            logic [31:0] instr_q, instr_d;
            logic        rd_valid_q, rd_valid_d;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instr_q    <= 32'h0000_0000;
                    rd_valid_q <= 1'b0;
                end else begin
                    instr_q    <= instr_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            always_comb begin
                instr_d    = instr_q;
                rd_valid_d = 1'b0;
                if (rd_en) begin
                    instr_d    = rd_word;
                    rd_valid_d = !busy;
                end
            end

            assign instruction = instr_q;
            assign rd_valid    = rd_valid_q;
        end else begin : g_comb_read
            logic unused_rd_en;

            assign unused_rd_en = rd_en;
            assign instruction  = rd_word;
            assign rd_valid     = !busy;
        end
    endgenerate

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: a combinational-fetch and a registered-fetch instance share stimulus
// and are checked against a byte-array reference model of the memory and its modes.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_start, load_start, load_valid, load_last;
    logic [AW-1:0] load_base, wr_addr, rd_addr;
    logic [7:0]    load_byte;
    logic          wr_en, rd_en;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    logic          busy0, load_ready0, wr_drop0, rd_valid0;
    logic [AW:0]   load_count0;
    logic [31:0]   instr0;
    logic          busy1, load_ready1, wr_drop1, rd_valid1;
    logic [AW:0]   load_count1;
    logic [31:0]   instr1;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .REG_READ(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clear_start(clear_start), .busy(busy0),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready0),
        .load_count(load_count0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_drop(wr_drop0), .rd_en(rd_en), .rd_addr(rd_addr),
        .instruction(instr0), .rd_valid(rd_valid0)
    );

    imem_loader #(.ADDR_W(AW), .REG_READ(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear_start(clear_start), .busy(busy1),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready1),
        .load_count(load_count1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_drop(wr_drop1), .rd_en(rd_en), .rd_addr(rd_addr),
        .instruction(instr1), .rd_valid(rd_valid1)
    );

    typedef struct {
        bit          v;
        logic [31:0] d;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    logic [31:0] q1[$];

    // Reference model: plain byte array plus mode flags.
    logic [7:0] mm [D];
    bit         m_clearing, m_loading, m_drop;
    int         m_left, m_ptr, m_count;

    function automatic logic [31:0] mword(int a);
        return {mm[(a + 3) % D], mm[(a + 2) % D], mm[(a + 1) % D], mm[a % D]};
    endfunction

    function automatic bit m_busy();
        return m_clearing || m_loading;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b1;
        m_left     = D / 4;
        m_loading  = 1'b0;
        m_ptr      = 0;
        m_count    = 0;
        m_drop     = 1'b0;
    endtask

    task automatic model_edge();
        m_drop = 1'b0;
        if (m_clearing) begin
            m_drop = wr_en;
            m_left--;
            if (m_left == 0) begin
                m_clearing = 1'b0;
                for (int i = 0; i < D; i++) mm[i] = 8'h00;
            end
        end else if (m_loading) begin
            m_drop = wr_en;
            if (load_valid) begin
                mm[m_ptr] = load_byte;
                m_ptr     = (m_ptr + 1) % D;
                if (m_count < D) m_count++;
                if (load_last) m_loading = 1'b0;
            end
        end else if (clear_start) begin
            m_clearing = 1'b1;
            m_left     = D / 4;
            m_drop     = wr_en;
        end else if (load_start) begin
            m_loading = 1'b1;
            m_ptr     = int'(load_base);
            m_count   = 0;
            m_drop    = wr_en;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (wr_be[k]) mm[(int'(wr_addr) + k) % D] = wr_data[8*k +: 8];
        end
    endtask

    // One clock: check status, queue the expected fetch results, advance the model.
    task automatic cycle();
        exp_t e;
        chk("busy0", busy0, m_busy());
        chk("busy1", busy1, m_busy());
        chk("load_ready0", load_ready0, m_loading);
        chk("load_count0", load_count0, m_count);
        chk("load_count1", load_count1, m_count);
        chk("wr_drop0", wr_drop0, m_drop);
        chk("wr_drop1", wr_drop1, m_drop);
        e.v = !m_busy();
        e.d = mword(int'(rd_addr));
        q0.push_back(e);
        if (rd_en && !m_busy()) q1.push_back(mword(int'(rd_addr)));
        if (reset) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_start = 0; load_start = 0; load_valid = 0; load_last = 0;
        wr_en = 0; rd_en = 0; load_base = '0; load_byte = '0;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        model_reset();
        q1.delete();
    endtask

    task automatic wait_clear(string name);
        int n = 0;
        while (busy0 && n < 200) begin
            cycle();
            n++;
        end
        chk(name, n, D / 4);
    endtask

    task automatic fetch_const(string name, int a, logic [31:0] req);
        rd_addr = a[AW-1:0];
        #1;
        chk(name, instr0, req);
        chk({name, "_valid"}, rd_valid0, 1);
        cycle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("rd_valid0", rd_valid0, e.v);
            if (e.v) chk("instr0", instr0, e.d);
        end
    end

    always @(negedge clk) begin
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid1_unexpected actual=1 required=0");
            end else begin
                chk("instr1", instr1, q1.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < D; i++) mm[i] = 8'h00;
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("reset_instr1", instr1, 32'h0);
        chk("reset_rd_valid1", rd_valid1, 0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        wait_clear("clear_cycles_initial");

        fetch_const("fetch_zero_80", 8'h80, 32'h0000_0000);

        wr_en = 1; wr_addr = 8'h10; wr_data = 32'hDEAD_BEEF; wr_be = 4'b0101;
        cycle();
        wr_en = 0;
        fetch_const("fetch_be0101", 8'h10, 32'h00AD_00EF);
        wr_en = 1; wr_addr = 8'hFE; wr_be = 4'b1111;
        cycle();
        wr_en = 0;
        fetch_const("fetch_FE", 8'hFE, 32'hDEAD_BEEF);
        fetch_const("fetch_wrap_00", 8'h00, 32'h0000_DEAD);

        load_start = 1; load_base = 8'h20;
        cycle();
        load_start = 0;
        chk("load_ready_after_start", load_ready0, 1);
        load_valid = 1; load_byte = 8'h13; cycle();
        load_valid = 0; cycle();
        load_valid = 1; load_byte = 8'h00; cycle();
        cycle();
        load_last = 1; cycle();
        load_valid = 0; load_last = 0;
        chk("load_count_4", load_count0, 4);
        chk("load_idle", busy0, 0);
        chk("load_ready_dropped", load_ready0, 0);
        fetch_const("fetch_loaded_20", 8'h20, 32'h0000_0013);

        load_start = 1; load_base = 8'h30;
        cycle();
        load_start = 0;
        load_valid = 1; load_byte = 8'h11; cycle();
        load_valid = 0;
        wr_en = 1; wr_addr = 8'h30; wr_data = 32'hFFFF_FFFF; wr_be = 4'b1111;
        cycle();
        wr_en = 0;
        chk("wr_drop_pulse", wr_drop0, 1);
        load_valid = 1; load_byte = 8'h22; load_last = 1;
        cycle();
        load_valid = 0; load_last = 0;
        chk("wr_drop_single", wr_drop0, 0);
        fetch_const("fetch_no_drop_write", 8'h30, 32'h0000_2211);

        load_start = 1; load_base = 8'h50;
        cycle();
        load_start = 0;
        load_valid = 1; load_byte = 8'hAA; cycle();
        load_byte = 8'hBB; cycle();
        load_byte = 8'hCC;
        assert_reset();
        chk("reset_load_count", load_count0, 0);
        chk("reset_busy", busy0, 1);
        load_valid = 0;
        cycle();
        cycle();
        reset = 1'b1;
        wait_clear("clear_cycles_after_abort");
        fetch_const("fetch_aborted_50", 8'h50, 32'h0000_0000);
        fetch_const("fetch_cleared_10", 8'h10, 32'h0000_0000);

        wr_en = 1; wr_addr = 8'h40; wr_data = 32'h1234_5678; wr_be = 4'b1111;
        rd_en = 1; rd_addr = 8'h40;
        cycle();
        wr_en = 0;
        chk("rr_old_data", instr1, 32'h0000_0000);
        chk("rr_latency_valid", rd_valid1, 1);
        cycle();
        rd_en = 0;
        chk("rr_new_data", instr1, 32'h1234_5678);
        cycle();
        chk("rr_valid_clears", rd_valid1, 0);

        load_start = 1; load_base = 8'hF0;
        cycle();
        load_start = 0;
        load_valid = 1;
        for (int i = 0; i < 258; i++) begin
            load_byte = i[7:0];
            load_last = (i == 257);
            cycle();
        end
        load_valid = 0; load_last = 0;
        chk("load_count_saturate", load_count0, D);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                assert_reset();
                cycle();
                cycle();
                reset = 1'b1;
            end
            clear_start = ($urandom_range(0, 299) == 0);
            load_start  = ($urandom_range(0, 24) == 0);
            load_base   = AW'($urandom);
            load_valid  = $urandom_range(0, 1);
            load_byte   = 8'($urandom);
            load_last   = ($urandom_range(0, 9) == 0);
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_addr     = AW'($urandom);
            wr_data     = $urandom;
            wr_be       = 4'($urandom);
            rd_en       = $urandom_range(0, 1);
            rd_addr     = AW'($urandom);
            cycle();
        end

        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
